vx_mask_serializer: RTL and testbench
=====================================

# vx_mask_serializer

- Consumes an N-lane active mask plus per-lane payload and emits the active lanes one per cycle, in priority order, over a valid/ready stream.
- Sits directly downstream of the team's prefix-scan primitive: an internal OR-scan of the remaining mask isolates the next active lane each cycle.
- Used wherever a thread-mask-qualified vector request must be split into scalar requests, e.g. per-lane memory or CSR side-channels.

## Interface
Parameters:
- N, 4, number of lanes (≥1); LOGN = max(1, $clog2(N))
- DATAW, 32, payload width per lane
- REVERSE, 0, lane service order: 0 = lowest index first, 1 = highest index first

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  reset; synchronous, active-high
- valid_in  in  1  input mask/payload valid
- mask_in  in  N  active-lane mask
- data_in  in  N*DATAW  lane payloads; lane i at [i*DATAW +: DATAW]
- ready_in  out  1  block accepts input this cycle
- valid_out  out  1  output beat valid
- data_out  out  DATAW  payload of the selected lane
- index_out  out  LOGN  index of the selected lane
- last_out  out  1  beat is the final active lane of its mask
- ready_out  in  1  downstream accepts the beat

## Operation
- State: busy flag, remaining-mask register rem[N], payload register buf[N*DATAW].
- Input handshake (accept) = valid_in & ready_in.
- ready_in = ~reset & (~busy | (valid_out & ready_out & last_out)).
- On accept:
  - rem ← mask_in; buf ← data_in.
  - busy ← (mask_in != 0).
  - A zero mask is accepted and discarded: it produces no output beat.
- Lane selection is combinational from rem:
  - s = OR-prefix-scan of rem in the service direction.
  - One-hot sel = rem & ~(s shifted one lane toward the unserved side).
  - index_out = binary encoding of sel; data_out = buf lane at index_out.
- valid_out = busy.
- last_out = busy & (rem & ~sel) == 0.
- Output handshake (valid_out & ready_out): rem ← rem & ~sel.
- If last_out is also set:
  - With no simultaneous accept: busy ← 0.
  - With a simultaneous accept: load the new mask per the accept rule (no bubble).
- Backpressure: while valid_out & ~ready_out, rem, buf and all outputs hold stable.
- N = 1: index_out = 0, and every beat has last_out = 1.

## Timing
- Reset values:
  - busy = 0, rem = 0, buf = 0.
  - Hence valid_out = 0, last_out = 0, index_out = 0, data_out = 0.
  - ready_in = 0 while reset is high and 1 in the first cycle after reset.
- Latency: a mask accepted at edge T presents its first beat in the cycle after T (1 cycle).
- Throughput:
  - One beat per cycle under ready_out = 1.
  - A mask with k active lanes occupies exactly k output cycles.
  - Consecutive masks run with zero bubble cycles.
- Reset mid-operation: the remaining lanes are dropped; valid_out = 0 from the cycle after the reset edge.
- A zero mask costs one accept cycle and leaves ready_in = 1.

## Configuration
- VX_MASK_SERIALIZER_OUTREG_EN defined:
  - Adds a registered output stage (a two-entry elastic buffer) holding valid/data/index/last.
  - Latency becomes 2 cycles; throughput stays one beat per cycle.
  - ready_out has no combinational path to ready_in.
  - Output reset values are unchanged.
- Undefined: the outputs are combinational from rem/buf, as described in Operation.

## Test plan
- N=4, mask_in=4'b1010, lanes 0..3 = 0x10,0x11,0x12,0x13, ready_out=1 -> beats (idx1, 0x11, last0) then (idx3, 0x13, last1) on the two cycles after accept; then valid_out=0.
- Back-to-back masks 4'b0001 then 4'b1000, valid_in held, ready_out=1 -> beats idx0 (last1) and idx3 (last1) on consecutive cycles; ready_in high on the last-beat cycle.
- mask_in=4'b0000 with valid_in=1 -> accepted; no valid_out; ready_in stays 1 the next cycle.
- mask_in=4'b0111, ready_out low for 3 cycles after the first beat -> idx0/data_out/last_out hold stable; then idx1, idx2 (last1) follow on consecutive cycles.
- REVERSE=1, mask_in=4'b1111 -> beat order idx3, 2, 1, 0; last_out only on idx0.
- reset asserted one cycle after the first beat of 4'b1111 -> valid_out=0 from the next cycle, remaining lanes never emitted; next mask 4'b0100 emits idx2 alone.

Source files
------------

// File: rtl/vx_mask_serializer.sv
// Serializes an N-lane active mask into one scalar beat per active lane, in priority order.
// Optional registered output stage: define VX_MASK_SERIALIZER_OUTREG_EN.
module vx_mask_serializer #(
  parameter int N       = 4,
  parameter int DATAW   = 32,
  parameter int REVERSE = 0,
  parameter int LOGN    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [N-1:0]       mask_in,
  input  logic [N*DATAW-1:0] data_in,
  output logic               ready_in,
  output logic               valid_out,
  output logic [DATAW-1:0]   data_out,
  output logic [LOGN-1:0]    index_out,
  output logic               last_out,
  input  logic               ready_out
);

  logic               busy;
  logic [N-1:0]       rem;
  logic [N*DATAW-1:0] pbuf;

  logic [N-1:0]       scan;
  logic [N-1:0]       sel;
  logic [LOGN-1:0]    c_idx;
  logic [DATAW-1:0]   c_data;
  logic               c_last;
  logic               c_ready;
  logic               c_fire;
  logic               accept;

  // OR-scan runs in the service direction; the first set bit of the scan is the next lane.
  always_comb begin
    scan = '0;
    sel  = '0;
    if (REVERSE == 0) begin
      scan[0] = rem[0];
      for (int unsigned i = 1; i < N; i++)
        scan[i] = scan[i-1] | rem[i];
      sel = rem & ~(scan << 1);
    end else begin
      scan[N-1] = rem[N-1];
      for (int unsigned i = N - 1; i > 0; i--)
        scan[i-1] = scan[i] | rem[i-1];
      sel = rem & ~(scan >> 1);
    end
  end

  always_comb begin
    c_idx  = '0;
    c_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel[i]) begin
        c_idx  = c_idx | LOGN'(i);
        c_data = c_data | pbuf[i*DATAW +: DATAW];
      end
    end
  end

  assign c_last   = busy & ~(|(rem & ~sel));
  assign c_fire   = busy & c_ready;
  assign ready_in = ~reset & (~busy | (c_fire & c_last));
  assign accept   = valid_in & ready_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      rem  <= '0;
      pbuf <= '0;
    end else if (accept) begin
      rem  <= mask_in;
      pbuf <= data_in;
      busy <= |mask_in;
    end else if (c_fire) begin
      rem <= rem & ~sel;
      if (c_last)
        busy <= 1'b0;
    end
  end

`ifdef VX_MASK_SERIALIZER_OUTREG_EN
  logic               skid_valid;
  logic [DATAW-1:0]   skid_data;
  logic [LOGN-1:0]    skid_idx;
  logic               skid_last;

  // Skid entry only fills when the output slot stalls, so ready depends on registered state only.
  assign c_ready = ~skid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      index_out  <= '0;
      last_out   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_idx   <= '0;
      skid_last  <= 1'b0;
    end else if (~valid_out | ready_out) begin
      if (skid_valid) begin
        valid_out  <= 1'b1;
        data_out   <= skid_data;
        index_out  <= skid_idx;
        last_out   <= skid_last;
        skid_valid <= 1'b0;
      end else begin
        valid_out <= c_fire;
        if (c_fire) begin
          data_out  <= c_data;
          index_out <= c_idx;
          last_out  <= c_last;
        end
      end
    end else if (c_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= c_data;
      skid_idx   <= c_idx;
      skid_last  <= c_last;
    end
  end
`else
  assign c_ready   = ready_out;
  assign valid_out = busy;
  assign data_out  = c_data;
  assign index_out = c_idx;
  assign last_out  = c_last;
`endif

endmodule

// File: tb/tb_vx_mask_serializer.sv
// Self-checking bench for vx_mask_serializer: directed scenarios plus a randomized run
// against a queue-based model of the expected beat stream.
module tb_vx_mask_serializer;

  localparam int N     = 4;
  localparam int DATAW = 32;
  localparam int LOGN  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in, ready_in, valid_out, last_out, ready_out;
  logic [N-1:0]     mask_in;
  logic [N*DATAW-1:0] data_in;
  logic [DATAW-1:0] data_out;
  logic [LOGN-1:0]  index_out;

  logic             r_valid_in, r_ready_in, r_valid_out, r_last_out, r_ready_out;
  logic [N-1:0]     r_mask_in;
  logic [N*DATAW-1:0] r_data_in;
  logic [DATAW-1:0] r_data_out;
  logic [LOGN-1:0]  r_index_out;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  vx_mask_serializer #(.N(N), .DATAW(DATAW), .REVERSE(0)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mask_in(mask_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out), .index_out(index_out),
    .last_out(last_out), .ready_out(ready_out)
  );

  vx_mask_serializer #(.N(N), .DATAW(DATAW), .REVERSE(1)) dut_r (
    .clk(clk), .reset(reset), .valid_in(r_valid_in), .mask_in(r_mask_in), .data_in(r_data_in),
    .ready_in(r_ready_in), .valid_out(r_valid_out), .data_out(r_data_out), .index_out(r_index_out),
    .last_out(r_last_out), .ready_out(r_ready_out)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; mask_in = '0; data_in = '0; ready_out = 1'b1;
    r_valid_in = 1'b0; r_mask_in = '0; r_data_in = '0; r_ready_out = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    nchecks++; if (ready_in !== 1'b0) begin nerrors++; $display("FAIL reset_ready_in: got %b exp 0", ready_in); end
    nchecks++; if (valid_out !== 1'b0) begin nerrors++; $display("FAIL reset_valid_out: got %b exp 0", valid_out); end
    nchecks++; if (last_out !== 1'b0) begin nerrors++; $display("FAIL reset_last_out: got %b exp 0", last_out); end
    nchecks++; if (index_out !== 2'd0) begin nerrors++; $display("FAIL reset_index_out: got %0d exp 0", index_out); end
    nchecks++; if (data_out !== 32'd0) begin nerrors++; $display("FAIL reset_data_out: got %h exp 0", data_out); end
    nchecks++; if (r_valid_out !== 1'b0) begin nerrors++; $display("FAIL reset_r_valid_out: got %b exp 0", r_valid_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    nchecks++; if (ready_in !== 1'b1) begin nerrors++; $display("FAIL post_reset_ready_in: got %b exp 1", ready_in); end
    next_cycle();
  endtask

  task automatic test_basic();
    valid_in = 1'b1; mask_in = 4'b1010; ready_out = 1'b1;
    data_in = {32'h13, 32'h12, 32'h11, 32'h10};
    @(negedge clk);
    nchecks++; if (ready_in !== 1'b1) begin nerrors++; $display("FAIL basic_ready_in: got %b exp 1", ready_in); end
    next_cycle();
    valid_in = 1'b0;
    @(negedge clk);
    nchecks++; if ({valid_out, index_out, data_out, last_out} !== {1'b1, 2'd1, 32'h11, 1'b0})
      begin nerrors++; $display("FAIL basic_beat0: got v%b i%0d d%h l%b exp v1 i1 d11 l0", valid_out, index_out, data_out, last_out); end
    next_cycle();
    @(negedge clk);
    nchecks++; if ({valid_out, index_out, data_out, last_out} !== {1'b1, 2'd3, 32'h13, 1'b1})
      begin nerrors++; $display("FAIL basic_beat1: got v%b i%0d d%h l%b exp v1 i3 d13 l1", valid_out, index_out, data_out, last_out); end
    next_cycle();
    @(negedge clk);
    nchecks++; if (valid_out !== 1'b0) begin nerrors++; $display("FAIL basic_idle: got %b exp 0", valid_out); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    valid_in = 1'b1; mask_in = 4'b0001; ready_out = 1'b1;
    data_in = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    next_cycle();
    mask_in = 4'b1000; data_in = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    @(negedge clk);
    nchecks++; if ({valid_out, index_out, data_out, last_out} !== {1'b1, 2'd0, 32'hA0, 1'b1})
      begin nerrors++; $display("FAIL b2b_beat0: got v%b i%0d d%h l%b exp v1 i0 dA0 l1", valid_out, index_out, data_out, last_out); end
    nchecks++; if (ready_in !== 1'b1) begin nerrors++; $display("FAIL b2b_ready_on_last: got %b exp 1", ready_in); end
    next_cycle();
    valid_in = 1'b0;
    @(negedge clk);
    nchecks++; if ({valid_out, index_out, data_out, last_out} !== {1'b1, 2'd3, 32'hB3, 1'b1})
      begin nerrors++; $display("FAIL b2b_beat1: got v%b i%0d d%h l%b exp v1 i3 dB3 l1", valid_out, index_out, data_out, last_out); end
    next_cycle();
    @(negedge clk);
    nchecks++; if (valid_out !== 1'b0) begin nerrors++; $display("FAIL b2b_idle: got %b exp 0", valid_out); end
    next_cycle();
  endtask

  task automatic test_zero_mask();
    valid_in = 1'b1; mask_in = 4'b0000; ready_out = 1'b1; data_in = '1;
    @(negedge clk);
    nchecks++; if (ready_in !== 1'b1) begin nerrors++; $display("FAIL zero_accept: got %b exp 1", ready_in); end
    next_cycle();
    valid_in = 1'b0;
    @(negedge clk);
    nchecks++; if (valid_out !== 1'b0) begin nerrors++; $display("FAIL zero_no_beat: got %b exp 0", valid_out); end
    nchecks++; if (ready_in !== 1'b1) begin nerrors++; $display("FAIL zero_ready_after: got %b exp 1", ready_in); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [N*DATAW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    valid_in = 1'b1; mask_in = 4'b0111; data_in = d; ready_out = 1'b1;
    next_cycle();
    valid_in = 1'b0; ready_out = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nchecks++; if ({valid_out, index_out, data_out, last_out} !== {1'b1, 2'd0, d[31:0], 1'b0})
        begin nerrors++; $display("FAIL bp_hold[%0d]: got v%b i%0d d%h l%b exp v1 i0 d%h l0", c, valid_out, index_out, data_out, last_out, d[31:0]); end
      nchecks++; if (ready_in !== 1'b0) begin nerrors++; $display("FAIL bp_ready_in[%0d]: got %b exp 0", c, ready_in); end
      next_cycle();
    end
    ready_out = 1'b1;
    @(negedge clk);
    nchecks++; if ({index_out, data_out, last_out} !== {2'd0, d[31:0], 1'b0})
      begin nerrors++; $display("FAIL bp_release0: got i%0d d%h l%b exp i0 d%h l0", index_out, data_out, last_out, d[31:0]); end
    next_cycle();
    @(negedge clk);
    nchecks++; if ({valid_out, index_out, data_out, last_out} !== {1'b1, 2'd1, d[63:32], 1'b0})
      begin nerrors++; $display("FAIL bp_beat1: got v%b i%0d d%h l%b exp v1 i1 d%h l0", valid_out, index_out, data_out, last_out, d[63:32]); end
    next_cycle();
    @(negedge clk);
    nchecks++; if ({valid_out, index_out, data_out, last_out} !== {1'b1, 2'd2, d[95:64], 1'b1})
      begin nerrors++; $display("FAIL bp_beat2: got v%b i%0d d%h l%b exp v1 i2 d%h l1", valid_out, index_out, data_out, last_out, d[95:64]); end
    next_cycle();
    @(negedge clk);
    nchecks++; if (valid_out !== 1'b0) begin nerrors++; $display("FAIL bp_idle: got %b exp 0", valid_out); end
    next_cycle();
  endtask

  task automatic test_reverse();
    logic [N*DATAW-1:0] d;
    int exp_idx;
    d = {$urandom, $urandom, $urandom, $urandom};
    r_valid_in = 1'b1; r_mask_in = 4'b1111; r_data_in = d; r_ready_out = 1'b1;
    next_cycle();
    r_valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_idx = 3 - k;
      @(negedge clk);
      nchecks++; if ({r_valid_out, r_index_out, r_data_out, r_last_out} !== {1'b1, 2'(exp_idx), d[exp_idx*DATAW +: DATAW], 1'(exp_idx == 0)})
        begin nerrors++; $display("FAIL rev_beat[%0d]: got v%b i%0d d%h l%b exp v1 i%0d d%h l%0d", k, r_valid_out, r_index_out, r_data_out, r_last_out, exp_idx, d[exp_idx*DATAW +: DATAW], exp_idx == 0); end
      next_cycle();
    end
    @(negedge clk);
    nchecks++; if (r_valid_out !== 1'b0) begin nerrors++; $display("FAIL rev_idle: got %b exp 0", r_valid_out); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    valid_in = 1'b1; mask_in = 4'b1111; ready_out = 1'b1;
    data_in = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    next_cycle();
    valid_in = 1'b0;
    @(negedge clk);
    nchecks++; if ({valid_out, index_out} !== {1'b1, 2'd0}) begin nerrors++; $display("FAIL rmid_first: got v%b i%0d exp v1 i0", valid_out, index_out); end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nchecks++; if (valid_out !== 1'b0) begin nerrors++; $display("FAIL rmid_dropped[%0d]: got %b exp 0", c, valid_out); end
      next_cycle();
    end
    valid_in = 1'b1; mask_in = 4'b0100; data_in = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    next_cycle();
    valid_in = 1'b0;
    @(negedge clk);
    nchecks++; if ({valid_out, index_out, data_out, last_out} !== {1'b1, 2'd2, 32'hD2, 1'b1})
      begin nerrors++; $display("FAIL rmid_next: got v%b i%0d d%h l%b exp v1 i2 dD2 l1", valid_out, index_out, data_out, last_out); end
    next_cycle();
    @(negedge clk);
    nchecks++; if (valid_out !== 1'b0) begin nerrors++; $display("FAIL rmid_idle: got %b exp 0", valid_out); end
    next_cycle();
  endtask

  // Model: the outstanding beats of the current mask, lowest lane first.
  task automatic test_random();
    int q_idx[$];
    logic [DATAW-1:0] q_dat[$];
    logic exp_valid, exp_ready;
    for (int c = 0; c < 400; c++) begin
      valid_in  = ($urandom_range(0, 2) != 0);
      mask_in   = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      data_in   = {$urandom, $urandom, $urandom, $urandom};
      ready_out = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_valid = (q_idx.size() != 0);
      exp_ready = (q_idx.size() == 0) || (q_idx.size() == 1 && ready_out);
      nchecks++; if (ready_in !== exp_ready) begin nerrors++; $display("FAIL rand_ready_in[%0d]: got %b exp %b", c, ready_in, exp_ready); end
      nchecks++; if (valid_out !== exp_valid) begin nerrors++; $display("FAIL rand_valid_out[%0d]: got %b exp %b", c, valid_out, exp_valid); end
      if (exp_valid) begin
        nchecks++; if ({index_out, data_out, last_out} !== {2'(q_idx[0]), q_dat[0], 1'(q_idx.size() == 1)})
          begin nerrors++; $display("FAIL rand_beat[%0d]: got i%0d d%h l%b exp i%0d d%h l%0d", c, index_out, data_out, last_out, q_idx[0], q_dat[0], q_idx.size() == 1); end
      end
      @(posedge clk);
      if (exp_valid && ready_out) begin
        void'(q_idx.pop_front());
        void'(q_dat.pop_front());
      end
      if (valid_in && exp_ready) begin
        for (int i = 0; i < N; i++) begin
          if (mask_in[i]) begin
            q_idx.push_back(i);
            q_dat.push_back(data_in[i*DATAW +: DATAW]);
          end
        end
      end
      #1;
    end
    valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_mask();
    test_backpressure();
    test_reverse();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
